reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised 2-read/1-write register file for the 16-bit RISC core, with
//  write-first bypass, optional hardwired-zero R0 and a per-register pending-write
//  scoreboard. Sits between decode (source reads, destination reservation) and
//  writeback (result writes). Reports read-after-write hazards to the stall logic.
// PARAMETERS
//  DATA_W   16  register width in bits
//  ADDR_W   3   select width; NUM_REGS = 2**ADDR_W
//  ZERO_R0  0   1: R0 always reads 0; writes and reservations to R0 are ignored
// PORTS
//  I_clk    in   1         clock; all state updates on the FALLING edge
//  I_rst    in   1         asynchronous active-high reset
//  I_en     in   1         block enable; 0 = no state change, O_valid forced low
//  I_re     in   1         read request for ports A and B
//  I_selA   in   ADDR_W    read select A
//  I_selB   in   ADDR_W    read select B
//  I_we     in   1         write enable (writeback)
//  I_selD   in   ADDR_W    write destination select
//  I_dataD  in   DATA_W    write data
//  I_rsv    in   1         reserve destination (mark pending)
//  I_selR   in   ADDR_W    register to reserve
//  O_dataA  out  DATA_W    registered read data A
//  O_dataB  out  DATA_W    registered read data B
//  O_valid  out  1         O_dataA/B updated on the last edge
//  O_hazA   out  1         source A was pending (unwritten) when read
//  O_hazB   out  1         source B was pending (unwritten) when read
//  O_busy   out  NUM_REGS  pending bitmap, bit n = register n awaiting write
// BEHAVIOUR
//  Reset (async, immediate): all registers 0, O_dataA/B 0, O_valid 0,
//   O_hazA/B 0, O_busy 0. Reset mid-operation discards any in-flight edge.
//  Write: falling edge with I_en & I_we -> regs[I_selD] <= I_dataD
//   (suppressed for selD==0 when ZERO_R0=1).
//  Read: falling edge with I_en & I_re -> O_dataA/B loaded, O_valid <= 1;
//   latency one falling edge. Otherwise O_dataA/B/O_hazA/B hold, O_valid <= 0.
//  Bypass (write-first): if same-edge write targets selA (selB), the read port
//   returns I_dataD, not the old value. Both ports may bypass simultaneously.
//  ZERO_R0=1: any read of R0 returns 0, O_haz for R0 is 0, bypass never applies.
//  Scoreboard, per register n on each falling edge with I_en:
//   set = I_rsv & selR==n; clr = I_we & selD==n;
//   set&clr -> pending stays 1 (newer producer wins); set only -> 1;
//   clr only -> 0; neither -> hold. O_busy is the pending vector directly.
//  Hazard: O_hazX <= pending[selX] & ~clr(selX) when a read is accepted
//   (same-edge write resolves the hazard because bypass supplies the data);
//   a same-edge reservation of selX does NOT raise O_hazX (read precedes it).
//  I_en=0: registers, pending bits and read outputs hold; O_valid <= 0.
//  Select width exactly ADDR_W; no out-of-range index possible.
// TESTING
//  1 Reset: assert I_rst mid-write of 16'hBEEF to R3 -> all outputs 0 at once,
//    later read of R3 returns 16'h0000.
//  2 Write/read: write R5=16'h1234, next edge read selA=5,selB=5 -> both 16'h1234,
//    O_valid=1 for one edge, then 0 with I_re=0 while data holds.
//  3 Bypass: same edge write R2=16'hA5A5 and read selA=2 (old 16'h0001) ->
//    O_dataA=16'hA5A5, O_hazA=0.
//  4 Scoreboard: reserve R4 -> O_busy[4]=1; read selB=4 -> O_hazB=1; write R4 ->
//    O_busy[4]=0; same-edge reserve+write R4 -> O_busy[4] stays 1.
//  5 ZERO_R0=1: write R0=16'hFFFF, reserve R0, read selA=0 -> O_dataA=0,
//    O_hazA=0, O_busy[0]=0.
//  6 Enable: I_en=0 with I_we/I_re/I_rsv high -> no register, busy or data change,
//    O_valid=0.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if
//   Bus bundle between decode/writeback (master) and the register file (slave).
//   Inputs to the register file:
//     I_en                block enable
//     I_re, I_selA/B      read request and read selects
//     I_we, I_selD/dataD  writeback enable, destination and data
//     I_rsv, I_selR       destination reservation and its select
//   Outputs from the register file:
//     O_dataA/B           registered read data
//     O_valid             read data updated on the last falling edge
//     O_hazA/B            source was pending when read
//     O_busy              pending-write bitmap, one bit per register
interface reg_file_sb_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   localparam int NUM_REGS = 2**ADDR_W;

   logic                I_en;
   logic                I_re;
   logic [ADDR_W-1:0]   I_selA;
   logic [ADDR_W-1:0]   I_selB;
   logic                I_we;
   logic [ADDR_W-1:0]   I_selD;
   logic [DATA_W-1:0]   I_dataD;
   logic                I_rsv;
   logic [ADDR_W-1:0]   I_selR;
   logic [DATA_W-1:0]   O_dataA;
   logic [DATA_W-1:0]   O_dataB;
   logic                O_valid;
   logic                O_hazA;
   logic                O_hazB;
   logic [NUM_REGS-1:0] O_busy;

   modport master (
      output I_en, I_re, I_selA, I_selB, I_we, I_selD, I_dataD, I_rsv, I_selR,
      input  O_dataA, O_dataB, O_valid, O_hazA, O_hazB, O_busy
   );

   modport slave (
      input  I_en, I_re, I_selA, I_selB, I_we, I_selD, I_dataD, I_rsv, I_selR,
      output O_dataA, O_dataB, O_valid, O_hazA, O_hazB, O_busy
   );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb
//   2-read/1-write register file with write-first bypass, optional hardwired
//   zero R0 and a per-register pending-write scoreboard. All state changes on
//   the FALLING edge of I_clk; I_rst is asynchronous active-high.
//   Ports:
//     I_clk  clock (falling-edge active)
//     I_rst  asynchronous reset, clears registers, scoreboard and outputs
//     bus    reg_file_sb_if.slave: read/write/reserve requests in,
//            read data, valid, hazard flags and busy bitmap out
module reg_file_sb #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 3,
   parameter int ZERO_R0 = 0
) (
   input logic           I_clk,
   input logic           I_rst,
   reg_file_sb_if.slave  bus
);
   localparam int unsigned NUM_REGS = 2**ADDR_W;

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] pend;
   logic [NUM_REGS-1:0] set_v;
   logic [NUM_REGS-1:0] clr_v;
   logic                wr_ok;
   logic                zero_a, zero_b;
   logic                byp_a, byp_b;
   logic [DATA_W-1:0]   data_a_nxt, data_b_nxt;
   logic                haz_a_nxt, haz_b_nxt;

   // A write to R0 is dropped entirely when R0 is hardwired, so it neither
   // updates storage nor acts as a bypass source.
   always_comb begin
      wr_ok = bus.I_we && !((ZERO_R0 != 0) && (bus.I_selD == '0));
   end

   // Scoreboard set/clear decode. Reservations of a hardwired R0 are ignored.
   always_comb begin
      set_v = '0;
      clr_v = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         set_v[i] = bus.I_rsv && (bus.I_selR == i[ADDR_W-1:0]) &&
                    !((ZERO_R0 != 0) && (i == 0));
         clr_v[i] = wr_ok && (bus.I_selD == i[ADDR_W-1:0]);
      end
   end

   // Read ports: hardwired zero beats bypass, bypass beats storage.
   // A same-edge write clears the hazard since the bypass supplies the data;
   // a same-edge reservation is ignored here because the read precedes it.
   always_comb begin
      zero_a = (ZERO_R0 != 0) && (bus.I_selA == '0);
      zero_b = (ZERO_R0 != 0) && (bus.I_selB == '0);
      byp_a  = wr_ok && (bus.I_selD == bus.I_selA);
      byp_b  = wr_ok && (bus.I_selD == bus.I_selB);

      if (zero_a)     data_a_nxt = '0;
      else if (byp_a) data_a_nxt = bus.I_dataD;
      else            data_a_nxt = regs[bus.I_selA];

      if (zero_b)     data_b_nxt = '0;
      else if (byp_b) data_b_nxt = bus.I_dataD;
      else            data_b_nxt = regs[bus.I_selB];

      haz_a_nxt = !zero_a && pend[bus.I_selA] && !clr_v[bus.I_selA];
      haz_b_nxt = !zero_b && pend[bus.I_selB] && !clr_v[bus.I_selB];
   end

   always_ff @(negedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         pend        <= '0;
         bus.O_dataA <= '0;
         bus.O_dataB <= '0;
         bus.O_valid <= 1'b0;
         bus.O_hazA  <= 1'b0;
         bus.O_hazB  <= 1'b0;
      end else begin
         bus.O_valid <= 1'b0;
         if (bus.I_en) begin
            if (wr_ok) begin
               regs[bus.I_selD] <= bus.I_dataD;
            end
            // Set after clear: a reservation on the same edge as the write
            // belongs to a newer producer, so the register stays pending.
            pend <= (pend & ~clr_v) | set_v;
            if (bus.I_re) begin
               bus.O_dataA <= data_a_nxt;
               bus.O_dataB <= data_b_nxt;
               bus.O_hazA  <= haz_a_nxt;
               bus.O_hazB  <= haz_b_nxt;
               bus.O_valid <= 1'b1;
            end
         end
      end
   end

   assign bus.O_busy = pend;
endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
   localparam int DW = 16;
   localparam int AW = 3;
   localparam int NR = 8;

   logic clk = 1'b1;
   logic rst = 1'b1;
   logic en = 1'b0, re = 1'b0, we = 1'b0, rsv = 1'b0;
   logic [AW-1:0] sel_a = '0, sel_b = '0, sel_d = '0, sel_r = '0;
   logic [DW-1:0] data_d = '0;
   logic done = 1'b0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
   reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

   assign bus0.I_en = en;     assign bus1.I_en = en;
   assign bus0.I_re = re;     assign bus1.I_re = re;
   assign bus0.I_selA = sel_a; assign bus1.I_selA = sel_a;
   assign bus0.I_selB = sel_b; assign bus1.I_selB = sel_b;
   assign bus0.I_we = we;     assign bus1.I_we = we;
   assign bus0.I_selD = sel_d; assign bus1.I_selD = sel_d;
   assign bus0.I_dataD = data_d; assign bus1.I_dataD = data_d;
   assign bus0.I_rsv = rsv;   assign bus1.I_rsv = rsv;
   assign bus0.I_selR = sel_r; assign bus1.I_selR = sel_r;

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(0)) dut0 (
      .I_clk(clk), .I_rst(rst), .bus(bus0));
   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1)) dut1 (
      .I_clk(clk), .I_rst(rst), .bus(bus1));

   typedef struct {
      logic [DW-1:0] a, b;
      logic          ha, hb;
   } rd_t;

   typedef struct {
      logic          v;
      logic [NR-1:0] busy;
      logic [DW-1:0] a, b;
      logic          ha, hb;
   } st_t;

   rd_t rd_q0[$], rd_q1[$];
   st_t st_q0[$], st_q1[$];

   // Reference model: instance 0 plain, instance 1 with hardwired-zero R0
   logic [DW-1:0] m_regs [2][NR];
   logic [NR-1:0] m_pend [2];
   st_t           m_out  [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < NR; r++) m_regs[k][r] = '0;
         m_pend[k] = '0;
         m_out[k].v = 1'b0; m_out[k].busy = '0;
         m_out[k].a = '0; m_out[k].b = '0;
         m_out[k].ha = 1'b0; m_out[k].hb = 1'b0;
      end
   endfunction

   function automatic logic [DW-1:0] model_read(input int k, input logic [AW-1:0] s,
                                                 output logic haz);
      if (k == 1 && s == 0) begin
         haz = 1'b0;
         return '0;
      end
      if (we && sel_d == s) begin
         haz = 1'b0;
         return data_d;
      end
      haz = m_pend[k][s];
      return m_regs[k][s];
   endfunction

   task automatic model_edge(input int k);
      rd_t r;
      st_t s;
      s = m_out[k];
      s.v = 1'b0;
      if (en) begin
         if (re) begin
            r.a = model_read(k, sel_a, r.ha);
            r.b = model_read(k, sel_b, r.hb);
            s.v = 1'b1;
            s.a = r.a; s.b = r.b; s.ha = r.ha; s.hb = r.hb;
            if (k == 0) rd_q0.push_back(r); else rd_q1.push_back(r);
         end
         if (we && !(k == 1 && sel_d == 0)) m_regs[k][sel_d] = data_d;
         if (we) m_pend[k][sel_d] = 1'b0;
         if (rsv && !(k == 1 && sel_r == 0)) m_pend[k][sel_r] = 1'b1;
      end
      s.busy = m_pend[k];
      m_out[k] = s;
      if (k == 0) st_q0.push_back(s); else st_q1.push_back(s);
   endtask

   // Called at a rising edge; applies one request set across the next falling edge.
   task automatic cyc(input logic e, input logic r, input logic [AW-1:0] sa,
                      input logic [AW-1:0] sb, input logic w, input logic [AW-1:0] sd,
                      input logic [DW-1:0] dd, input logic rv, input logic [AW-1:0] sr);
      en = e; re = r; sel_a = sa; sel_b = sb; we = w; sel_d = sd; data_d = dd;
      rsv = rv; sel_r = sr;
      @(negedge clk);
      if (!rst) begin
         model_edge(0);
         model_edge(1);
      end
      @(posedge clk);
   endtask

   function automatic st_t grab(input int k);
      st_t g;
      if (k == 0) begin
         g.v = bus0.O_valid; g.busy = bus0.O_busy; g.a = bus0.O_dataA;
         g.b = bus0.O_dataB; g.ha = bus0.O_hazA; g.hb = bus0.O_hazB;
      end else begin
         g.v = bus1.O_valid; g.busy = bus1.O_busy; g.a = bus1.O_dataA;
         g.b = bus1.O_dataB; g.ha = bus1.O_hazA; g.hb = bus1.O_hazB;
      end
      return g;
   endfunction

   task automatic mon_one(input int k, input st_t g);
      st_t e;
      rd_t r;
      string p;
      p = (k == 0) ? "i0" : "i1";
      if ((k == 0 ? st_q0.size() : st_q1.size()) == 0) begin
         chk({p, "_state_queue_empty"}, 32'd1, 32'd0);
         return;
      end
      e = (k == 0) ? st_q0.pop_front() : st_q1.pop_front();
      chk({p, "_valid"}, {31'd0, g.v}, {31'd0, e.v});
      chk({p, "_busy"}, {24'd0, g.busy}, {24'd0, e.busy});
      if (g.v) begin
         if ((k == 0 ? rd_q0.size() : rd_q1.size()) == 0) begin
            chk({p, "_unexpected_read"}, 32'd1, 32'd0);
            return;
         end
         r = (k == 0) ? rd_q0.pop_front() : rd_q1.pop_front();
         chk({p, "_dataA"}, {16'd0, g.a}, {16'd0, r.a});
         chk({p, "_dataB"}, {16'd0, g.b}, {16'd0, r.b});
         chk({p, "_hazA"}, {31'd0, g.ha}, {31'd0, r.ha});
         chk({p, "_hazB"}, {31'd0, g.hb}, {31'd0, r.hb});
      end else begin
         chk({p, "_holdA"}, {16'd0, g.a}, {16'd0, e.a});
         chk({p, "_holdB"}, {16'd0, g.b}, {16'd0, e.b});
         chk({p, "_holdHazA"}, {31'd0, g.ha}, {31'd0, e.ha});
         chk({p, "_holdHazB"}, {31'd0, g.hb}, {31'd0, e.hb});
      end
   endtask

   // Monitor: compares every non-reset falling edge against the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (done) break;
         if (!rst) begin
            mon_one(0, grab(0));
            mon_one(1, grab(1));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      rst = 1'b0;

      // write then read the same register on both ports
      cyc(1, 0, 0, 0, 1, 5, 16'h1234, 0, 0);
      cyc(1, 1, 5, 5, 0, 0, 16'h0000, 0, 0);
      chk("wr_rd_dataA", {16'd0, bus0.O_dataA}, 32'h1234);
      chk("wr_rd_dataB", {16'd0, bus0.O_dataB}, 32'h1234);
      chk("wr_rd_valid", {31'd0, bus0.O_valid}, 32'd1);
      cyc(1, 0, 0, 0, 0, 0, 16'h0000, 0, 0);
      chk("idle_valid", {31'd0, bus0.O_valid}, 32'd0);
      chk("idle_hold", {16'd0, bus0.O_dataA}, 32'h1234);

      // write-first bypass
      cyc(1, 0, 0, 0, 1, 2, 16'h0001, 0, 0);
      cyc(1, 1, 2, 5, 1, 2, 16'hA5A5, 0, 0);
      chk("bypass_dataA", {16'd0, bus0.O_dataA}, 32'hA5A5);
      chk("bypass_hazA", {31'd0, bus0.O_hazA}, 32'd0);

      // scoreboard
      cyc(1, 0, 0, 0, 0, 0, 16'h0000, 1, 4);
      chk("rsv_busy4", {31'd0, bus0.O_busy[4]}, 32'd1);
      cyc(1, 1, 1, 4, 0, 0, 16'h0000, 0, 0);
      chk("rsv_hazB", {31'd0, bus0.O_hazB}, 32'd1);
      cyc(1, 0, 0, 0, 1, 4, 16'h9999, 0, 0);
      chk("wr_clears_busy4", {31'd0, bus0.O_busy[4]}, 32'd0);
      cyc(1, 0, 0, 0, 1, 4, 16'h4444, 1, 4);
      chk("rsv_wr_busy4", {31'd0, bus0.O_busy[4]}, 32'd1);
      cyc(1, 1, 4, 4, 1, 4, 16'h5555, 1, 4);

      // hardwired R0 on instance 1
      cyc(1, 0, 0, 0, 1, 0, 16'hFFFF, 1, 0);
      cyc(1, 1, 0, 4, 0, 0, 16'h0000, 0, 0);
      chk("zero_dataA", {16'd0, bus1.O_dataA}, 32'h0000);
      chk("zero_hazA", {31'd0, bus1.O_hazA}, 32'd0);
      chk("zero_busy0", {31'd0, bus1.O_busy[0]}, 32'd0);
      chk("nozero_dataA", {16'd0, bus0.O_dataA}, 32'hFFFF);

      // block disabled
      cyc(0, 1, 1, 2, 1, 3, 16'h7777, 1, 6);
      chk("en0_valid", {31'd0, bus0.O_valid}, 32'd0);
      chk("en0_busy6", {31'd0, bus0.O_busy[6]}, 32'd0);

      // reset in the middle of a write
      en = 1; re = 1; sel_a = 3; sel_b = 4; we = 1; sel_d = 3; data_d = 16'hBEEF;
      rsv = 1; sel_r = 7;
      #2 rst = 1'b1;
      #1;
      chk("rst_dataA", {16'd0, bus0.O_dataA}, 32'd0);
      chk("rst_dataB", {16'd0, bus1.O_dataB}, 32'd0);
      chk("rst_busy", {24'd0, bus0.O_busy}, 32'd0);
      chk("rst_haz", {30'd0, bus0.O_hazA, bus0.O_hazB}, 32'd0);
      chk("rst_valid", {30'd0, bus0.O_valid, bus1.O_valid}, 32'd0);
      model_reset();
      @(posedge clk);
      rst = 1'b0;
      cyc(1, 1, 3, 3, 0, 0, 16'h0000, 0, 0);
      chk("rst_r3", {16'd0, bus0.O_dataA}, 32'h0000);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) < 3),
             AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
             $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)),
             DW'($urandom), ($urandom_range(0, 9) < 3), AW'($urandom_range(0, 7)));
      end
      cyc(1, 0, 0, 0, 0, 0, 16'h0000, 0, 0);

      #4;
      done = 1'b1;
      chk("rd_q0_drained", rd_q0.size(), 32'd0);
      chk("rd_q1_drained", rd_q1.size(), 32'd0);
      chk("st_q0_drained", st_q0.size(), 32'd0);
      chk("st_q1_drained", st_q1.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
